// File: rtl/pipeline_pkg.sv
// Shared definitions for the WB commit-trace path: field widths, packed-entry
// layout helpers and the capture freeze state.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    // Entry layout, LSB first: RegWrite | rd_addr | write_data | instruction | pc
    localparam int RW_OFS = 0;
    localparam int RD_OFS = RW_OFS + 1;
    localparam int WD_OFS = RD_OFS + REG_ADDR_W;

    function automatic int trace_w(input int xlen);
        return 3 * xlen + REG_ADDR_W + 1;
    endfunction

    function automatic int instr_ofs(input int xlen);
        return WD_OFS + xlen;
    endfunction

    function automatic int pc_ofs(input int xlen);
        return WD_OFS + 2 * xlen;
    endfunction

    typedef enum logic {
        CAPTURE_LIVE   = 1'b0,
        CAPTURE_FROZEN = 1'b1
    } capture_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the head entry.
// Push is refused when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/wb_trace_buffer.sv
// Commit-trace buffer for the WB stage: filters retired instructions into a
// FIFO drained over valid/ready, with drop/retire accounting and freeze-on-full.
module wb_trace_buffer
    import pipeline_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 32,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    filter_rw_only,
    input  logic                    wb_valid,
    input  logic [XLEN-1:0]         wb_pc,
    input  logic [XLEN-1:0]         wb_instruction,
    input  logic [XLEN-1:0]         wb_write_data,
    input  logic [REG_ADDR_W-1:0]   wb_rd_addr,
    input  logic                    wb_RegWrite,
    output logic                    tr_valid,
    input  logic                    tr_ready,
    output logic [XLEN-1:0]         tr_pc,
    output logic [XLEN-1:0]         tr_instruction,
    output logic [XLEN-1:0]         tr_write_data,
    output logic [REG_ADDR_W-1:0]   tr_rd_addr,
    output logic                    tr_RegWrite,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_count,
    output logic [CNT_W-1:0]        retired_count
);

    localparam int TW    = trace_w(XLEN);
    localparam int INS_O = instr_ofs(XLEN);
    localparam int PC_O  = pc_ofs(XLEN);

    capture_state_e   state_reg, state_next;
    logic             frozen;
    logic             writes_reg;
    logic             cap, push, pop, drop;
    logic [TW-1:0]    wr_entry;
    logic [TW-1:0]    head;
    logic             overflow_reg;
    logic [CNT_W-1:0] drop_count_reg;
    logic [CNT_W-1:0] retired_count_reg;

    assign frozen     = (state_reg == CAPTURE_FROZEN);
    assign writes_reg = wb_RegWrite & (wb_rd_addr != '0);
    assign cap        = en & wb_valid & ~frozen & (~filter_rw_only | writes_reg);
    assign pop        = tr_valid & tr_ready;
    assign push       = cap & (~full | pop);
    assign drop       = cap & full & ~pop;

    assign wr_entry = {wb_pc, wb_instruction, wb_write_data, wb_rd_addr, wb_RegWrite};

    sync_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= CAPTURE_LIVE;
        else
            state_reg <= state_next;
    end

    // Once frozen, only clear (or reset) re-arms capture.
    always_comb begin
        state_next = state_reg;
        if (clear)
            state_next = CAPTURE_LIVE;
        else if (STOP_ON_FULL != 0 && drop)
            state_next = CAPTURE_FROZEN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg      <= 1'b0;
            drop_count_reg    <= '0;
            retired_count_reg <= '0;
        end else if (clear) begin
            overflow_reg      <= 1'b0;
            drop_count_reg    <= '0;
            retired_count_reg <= '0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != '1)
                    drop_count_reg <= drop_count_reg + 1'b1;
            end
            if (wb_valid)
                retired_count_reg <= retired_count_reg + 1'b1;
        end
    end

    // Data outputs read as zero while nothing is queued, hiding stale RAM.
    assign tr_valid       = ~empty;
    assign tr_pc          = empty ? '0 : head[PC_O +: XLEN];
    assign tr_instruction = empty ? '0 : head[INS_O +: XLEN];
    assign tr_write_data  = empty ? '0 : head[WD_OFS +: XLEN];
    assign tr_rd_addr     = empty ? '0 : head[RD_OFS +: REG_ADDR_W];
    assign tr_RegWrite    = empty ? 1'b0 : head[RW_OFS];

    assign overflow      = overflow_reg;
    assign drop_count    = drop_count_reg;
    assign retired_count = retired_count_reg;

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Parametrised commit-trace buffer that sits beside `pipeline_topo` and captures every instruction retired at the WB stage (pc, instruction, write data, rd, RegWrite) into a DEPTH-entry FIFO, drained through a valid/ready port. It replaces one-cycle WB debug taps that a testbench must sample live. Adds a register-write-only filter, overflow accounting, a retired-instruction counter and a stop-on-full freeze mode.

## Interface
- XLEN, 32, datapath width of pc/instruction/write data
- DEPTH, 8, FIFO entries; power of two, ≥2
- CNT_W, 32, width of retired_count and drop_count
- STOP_ON_FULL, 0, 0 = drop newest commit when full; 1 = freeze capture after first drop until clear
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous flush of FIFO, counters, overflow, freeze
- en  in  1  capture enable
- filter_rw_only  in  1  capture only commits with wb_RegWrite=1 and wb_rd_addr≠0
- wb_valid  in  1  one-cycle strobe per retired instruction
- wb_pc, wb_instruction, wb_write_data  in  XLEN each  WB commit fields
- wb_rd_addr  in  5  destination register
- wb_RegWrite  in  1  register-write flag
- tr_valid  out  1  head entry present
- tr_ready  in  1  consumer accepts head
- tr_pc, tr_instruction, tr_write_data  out  XLEN each  head entry fields
- tr_rd_addr  out  5; tr_RegWrite  out  1
- count  out  $clog2(DEPTH)+1  occupancy
- full, empty  out  1 each
- overflow  out  1  sticky, set on first dropped commit
- drop_count  out  CNT_W  saturating count of dropped commits
- retired_count  out  CNT_W  wrapping count of all wb_valid strobes

## Operation
- cap = en & wb_valid & ~frozen & (~filter_rw_only | (wb_RegWrite & wb_rd_addr≠0)).
- pop = tr_valid & tr_ready. push = cap & (~full | pop); push and pop in the same cycle when full are both accepted, count unchanged.
- drop = cap & full & ~pop: drop_count += 1 (saturate at all-ones), overflow ← 1; if STOP_ON_FULL=1, frozen ← 1.
- Filtered-out, disabled or frozen commits are not drops.
- retired_count increments on every wb_valid regardless of en, filter, frozen; wraps modulo 2^CNT_W.
- Show-ahead FIFO: tr_* = head entry; tr_valid = ~empty; all tr_* data outputs driven to 0 while empty.
- Pointers $clog2(DEPTH) bits, wrap naturally; full/empty from count.
- clear: count, pointers, drop_count, retired_count, overflow, frozen → 0; clear wins over same-cycle push/pop/increment.
- Reset (async, any time, including mid-drain): same values as clear; all outputs 0, empty=1. FIFO storage not reset.

## Timing
- Commit accepted at edge N → tr_valid=1 and fields visible after edge N (1-cycle latency).
- Pop at edge N → next entry (or empty) visible after edge N.
- full/empty/count/overflow/drop_count/retired_count registered, update at the same edge as the event.
- Back-to-back wb_valid every cycle sustained with tr_ready=1: no drops, no bubbles.
- tr_* held stable while tr_valid=1 & tr_ready=0.

## Structure
- Shared package/header `pipeline_pkg`: trace entry field widths, REG_ADDR_W=5, TRACE_W = 3·XLEN+6, entry pack/unpack field offsets.
- One sub-module: `sync_fifo` (WIDTH, DEPTH; push, pop, rd_data, count, full, empty); wb_trace_buffer adds filter, counters, freeze and output zeroing.

## Test plan
- Reset mid-operation: 3 entries queued, assert reset → count=0, empty=1, tr_valid=0, tr_pc=0 immediately (asynchronous).
- 4 commits pc=0x0,0x4,0x8,0xC, tr_ready=1 → drained in order, each one cycle after commit; retired_count=4, drop_count=0.
- DEPTH=8, tr_ready=0, 10 commits → count=8, full=1, overflow=1, drop_count=2; head pc of 1st commit; drain yields first 8 in order.
- Full, simultaneous commit and pop → count stays 8, no drop, new entry appended at tail.
- filter_rw_only=1, commits {RegWrite=1 rd=5, RegWrite=0 rd=3, RegWrite=1 rd=0} → only rd=5 captured; retired_count=3.
- STOP_ON_FULL=1: fill, one drop, drain fully, 2 more commits → not captured (frozen); pulse clear → next commit captured, counters 0 then retired_count=1.
